fft_peak_detect: RTL and testbench



---
 rtl/fft_peak_detect.sv | 154 +++++++++++++++
 tb/tb_fft_peak_detect.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_detect.sv
// Streaming FFT post-processor: per-bin squared magnitude (2-stage pipeline)
// and per-frame peak-bin search on the registered magnitude stream.
module fft_peak_detect #(
    parameter int REAL_WIDTH  = 18,
    parameter int IMGN_WIDTH  = 18,
    parameter int TOTAL_STAGE = 8,
    parameter int SKIP_DC     = 1,
    parameter int MAG_WIDTH   = 2 * ((REAL_WIDTH > IMGN_WIDTH) ? REAL_WIDTH : IMGN_WIDTH)
) (
    input  logic                   clk_in,
    input  logic                   RST,
    input  logic [REAL_WIDTH-1:0]  iReal,
    input  logic [IMGN_WIDTH-1:0]  iImag,
    input  logic [TOTAL_STAGE-1:0] iaddr,
    input  logic                   ien,
    output logic [MAG_WIDTH-1:0]   mag_o,
    output logic [TOTAL_STAGE-1:0] mag_addr,
    output logic                   mag_en,
    output logic [TOTAL_STAGE-1:0] peak_bin,
    output logic [MAG_WIDTH-1:0]   peak_mag,
    output logic                   peak_valid,
    output logic                   frame_err
);

    localparam int PR_W = 2 * REAL_WIDTH;
    localparam int PI_W = 2 * IMGN_WIDTH;

    typedef enum logic {
        S_IDLE,
        S_ACCUM
    } state_t;

    logic signed [PR_W-1:0] re_ext;
    logic signed [PI_W-1:0] im_ext;
    logic signed [PR_W-1:0] re_sq_d, re_sq_q;
    logic signed [PI_W-1:0] im_sq_d, im_sq_q;
    logic [TOTAL_STAGE-1:0] addr1_q;
    logic                   en1_q;

    logic [MAG_WIDTH-1:0]   mag_d, mag_q;
    logic [TOTAL_STAGE-1:0] addr2_q;
    logic                   en2_q;

    state_t                 state_q;
    logic [TOTAL_STAGE-1:0] cnt_q;
    logic [MAG_WIDTH-1:0]   max_mag_q;
    logic [TOTAL_STAGE-1:0] max_bin_q;
    logic [TOTAL_STAGE-1:0] peak_bin_q;
    logic [MAG_WIDTH-1:0]   peak_mag_q;
    logic                   peak_valid_q;
    logic                   frame_err_q;

    logic                   is_bin0;
    logic                   cand_gt;
    logic                   last_smp;
    logic [MAG_WIDTH-1:0]   seed_mag;

    // Products are non-negative, so zero-extending them before the add is exact.
    always_comb begin
        re_ext  = PR_W'($signed(iReal));
        im_ext  = PI_W'($signed(iImag));
        re_sq_d = re_ext * re_ext;
        im_sq_d = im_ext * im_ext;
        mag_d   = MAG_WIDTH'($unsigned(re_sq_q)) + MAG_WIDTH'($unsigned(im_sq_q));
    end

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            re_sq_q <= '0;
            im_sq_q <= '0;
            addr1_q <= '0;
            en1_q   <= 1'b0;
            mag_q   <= '0;
            addr2_q <= '0;
            en2_q   <= 1'b0;
        end else begin
            re_sq_q <= re_sq_d;
            im_sq_q <= im_sq_d;
            addr1_q <= iaddr;
            en1_q   <= ien;
            mag_q   <= mag_d;
            addr2_q <= addr1_q;
            en2_q   <= en1_q;
        end
    end

    // cnt_q all-ones means this accepted sample is the N-th of the frame.
    always_comb begin
        is_bin0  = (addr2_q == '0);
        cand_gt  = (mag_q > max_mag_q);
        last_smp = (cnt_q == '1);
        seed_mag = (SKIP_DC != 0) ? '0 : mag_q;
    end

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            max_mag_q    <= '0;
            max_bin_q    <= '0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
            peak_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            peak_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (en2_q && is_bin0) begin
                        state_q   <= S_ACCUM;
                        cnt_q     <= TOTAL_STAGE'(1);
                        max_bin_q <= '0;
                        max_mag_q <= seed_mag;
                    end
                end
                S_ACCUM: begin
                    if (en2_q) begin
                        if (is_bin0) begin
                            frame_err_q <= 1'b1;
                            cnt_q       <= TOTAL_STAGE'(1);
                            max_bin_q   <= '0;
                            max_mag_q   <= seed_mag;
                        end else if (last_smp) begin
                            state_q      <= S_IDLE;
                            cnt_q        <= '0;
                            peak_valid_q <= 1'b1;
                            peak_bin_q   <= cand_gt ? addr2_q : max_bin_q;
                            peak_mag_q   <= cand_gt ? mag_q : max_mag_q;
                            max_bin_q    <= '0;
                            max_mag_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + TOTAL_STAGE'(1);
                            if (cand_gt) begin
                                max_bin_q <= addr2_q;
                                max_mag_q <= mag_q;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mag_o      = mag_q;
    assign mag_addr   = addr2_q;
    assign mag_en     = en2_q;
    assign peak_bin   = peak_bin_q;
    assign peak_mag   = peak_mag_q;
    assign peak_valid = peak_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Bench for fft_peak_detect: two instances (SKIP_DC=1 / SKIP_DC=0) on the same
// stream, checked every cycle against a frame-list reference model.
module tb_fft_peak_detect;

    localparam int RW   = 18;
    localparam int IW   = 18;
    localparam int TS   = 8;
    localparam int N    = 256;
    localparam int MW   = 36;
    localparam int MAXC = 30000;

    logic          clk_in = 1'b0;
    logic          RST    = 1'b1;
    logic [RW-1:0] iReal  = '0;
    logic [IW-1:0] iImag  = '0;
    logic [TS-1:0] iaddr  = '0;
    logic          ien    = 1'b0;

    logic [MW-1:0] mag_o_w      [2];
    logic [TS-1:0] mag_addr_w   [2];
    logic          mag_en_w     [2];
    logic [TS-1:0] peak_bin_w   [2];
    logic [MW-1:0] peak_mag_w   [2];
    logic          peak_valid_w [2];
    logic          frame_err_w  [2];

    always #5 clk_in = ~clk_in;

    fft_peak_detect #(.REAL_WIDTH(RW), .IMGN_WIDTH(IW), .TOTAL_STAGE(TS),
                      .SKIP_DC(1), .MAG_WIDTH(MW)) u_skip (
        .clk_in(clk_in), .RST(RST), .iReal(iReal), .iImag(iImag), .iaddr(iaddr), .ien(ien),
        .mag_o(mag_o_w[0]), .mag_addr(mag_addr_w[0]), .mag_en(mag_en_w[0]),
        .peak_bin(peak_bin_w[0]), .peak_mag(peak_mag_w[0]),
        .peak_valid(peak_valid_w[0]), .frame_err(frame_err_w[0]));

    fft_peak_detect #(.REAL_WIDTH(RW), .IMGN_WIDTH(IW), .TOTAL_STAGE(TS),
                      .SKIP_DC(0), .MAG_WIDTH(MW)) u_keep (
        .clk_in(clk_in), .RST(RST), .iReal(iReal), .iImag(iImag), .iaddr(iaddr), .ien(ien),
        .mag_o(mag_o_w[1]), .mag_addr(mag_addr_w[1]), .mag_en(mag_en_w[1]),
        .peak_bin(peak_bin_w[1]), .peak_mag(peak_mag_w[1]),
        .peak_valid(peak_valid_w[1]), .frame_err(frame_err_w[1]));

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    bit          rec_en   [MAXC];
    int          rec_re   [MAXC];
    int          rec_im   [MAXC];
    int          rec_addr [MAXC];
    bit          exp_pv   [2][MAXC];
    bit          exp_fe   [2][MAXC];
    int          exp_pb   [2][MAXC];
    logic [63:0] exp_pm   [2][MAXC];

    bit          active  [2];
    int          fcount  [2];
    int          fbin    [2][N];
    logic [63:0] fmag    [2][N];
    int          held_pb [2];
    logic [63:0] held_pm [2];
    int          pv_cnt  [2];
    int          fe_cnt  [2];

    int tre [N];
    int tim [N];

    task automatic check(input int k, input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, k, cyc, act, exp);
    endtask

    function automatic logic [63:0] sqmag(input int re, input int im);
        longint a;
        longint b;
        a = re;
        b = im;
        return 64'(a * a + b * b);
    endfunction

    // Frame reference: collect accepted samples, pick the strict-greater
    // (earliest-on-tie) maximum once N samples are in hand.
    task automatic model_sample(input int k, input int addr, input logic [63:0] m, input int c);
        int          bb;
        logic [63:0] bm;
        if (addr == 0) begin
            if (active[k] && c + 3 < MAXC) exp_fe[k][c+3] = 1'b1;
            fcount[k]  = 1;
            fbin[k][0] = 0;
            fmag[k][0] = m;
            active[k]  = 1'b1;
        end else if (active[k]) begin
            fbin[k][fcount[k]] = addr;
            fmag[k][fcount[k]] = m;
            fcount[k]++;
            if (fcount[k] == N) begin
                bb = 0;
                bm = 64'd0;
                for (int i = 0; i < N; i++) begin
                    if (!(k == 0 && fbin[k][i] == 0) && fmag[k][i] > bm) begin
                        bb = fbin[k][i];
                        bm = fmag[k][i];
                    end
                end
                if (c + 3 < MAXC) begin
                    exp_pv[k][c+3] = 1'b1;
                    exp_pb[k][c+3] = bb;
                    exp_pm[k][c+3] = bm;
                end
                active[k] = 1'b0;
                fcount[k] = 0;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            active[k]  = 1'b0;
            fcount[k]  = 0;
            held_pb[k] = 0;
            held_pm[k] = 64'd0;
            for (int c = cyc; c < cyc + 5 && c < MAXC; c++) begin
                exp_pv[k][c] = 1'b0;
                exp_fe[k][c] = 1'b0;
            end
        end
        for (int c = cyc - 2; c <= cyc; c++)
            if (c >= 0) rec_en[c] = 1'b0;
    endtask

    always @(posedge clk_in) cyc++;

    always @(negedge clk_in) begin
        bit e2;
        if (RST) begin
            model_reset();
        end else if (cyc < MAXC) begin
            rec_en[cyc]   = ien;
            rec_re[cyc]   = int'($signed(iReal));
            rec_im[cyc]   = int'($signed(iImag));
            rec_addr[cyc] = int'(iaddr);
            if (ien)
                for (int k = 0; k < 2; k++)
                    model_sample(k, int'(iaddr), sqmag(rec_re[cyc], rec_im[cyc]), cyc);
            for (int k = 0; k < 2; k++) begin
                if (exp_pv[k][cyc]) begin
                    held_pb[k] = exp_pb[k][cyc];
                    held_pm[k] = exp_pm[k][cyc];
                end
                e2 = (cyc >= 2) ? rec_en[cyc-2] : 1'b0;
                check(k, "mag_en", 64'(mag_en_w[k]), 64'(e2));
                if (e2) begin
                    check(k, "mag_o", 64'(mag_o_w[k]), sqmag(rec_re[cyc-2], rec_im[cyc-2]));
                    check(k, "mag_addr", 64'(mag_addr_w[k]), 64'(rec_addr[cyc-2]));
                end
                check(k, "peak_valid", 64'(peak_valid_w[k]), 64'(exp_pv[k][cyc]));
                check(k, "frame_err", 64'(frame_err_w[k]), 64'(exp_fe[k][cyc]));
                check(k, "peak_bin", 64'(peak_bin_w[k]), 64'(held_pb[k]));
                check(k, "peak_mag", 64'(peak_mag_w[k]), held_pm[k]);
                if (peak_valid_w[k]) pv_cnt[k]++;
                if (frame_err_w[k]) fe_cnt[k]++;
            end
        end
    end

    function automatic int rnd18();
        logic [17:0] r;
        r = 18'($urandom);
        return int'($signed(r));
    endfunction

    function automatic int bitrev(input int v);
        int r;
        r = 0;
        for (int b = 0; b < TS; b++) if (v[b]) r |= 1 << (TS - 1 - b);
        return r;
    endfunction

    task automatic drive(input bit en, input int re, input int im, input int addr);
        @(posedge clk_in);
        #1;
        ien   = en;
        iReal = RW'(re);
        iImag = IW'(im);
        iaddr = TS'(addr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0);
    endtask

    task automatic clear_tone();
        for (int i = 0; i < N; i++) begin
            tre[i] = 0;
            tim[i] = 0;
        end
    endtask

    // gap_mode: 0 contiguous, 1 alternate valid/idle, 2 random idle cycles
    task automatic send_frame(input int nb, input int gap_mode, input bit brev);
        int a;
        for (int i = 0; i < nb; i++) begin
            a = brev ? bitrev(i) : i;
            drive(1'b1, tre[a], tim[a], a);
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0))
                drive(1'b0, rnd18(), rnd18(), int'($urandom_range(0, N - 1)));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check(k, {tag, " mag_o"}, 64'(mag_o_w[k]), 64'd0);
            check(k, {tag, " mag_addr"}, 64'(mag_addr_w[k]), 64'd0);
            check(k, {tag, " mag_en"}, 64'(mag_en_w[k]), 64'd0);
            check(k, {tag, " peak_bin"}, 64'(peak_bin_w[k]), 64'd0);
            check(k, {tag, " peak_mag"}, 64'(peak_mag_w[k]), 64'd0);
            check(k, {tag, " peak_valid"}, 64'(peak_valid_w[k]), 64'd0);
            check(k, {tag, " frame_err"}, 64'(frame_err_w[k]), 64'd0);
        end
    endtask

    task automatic check_peak(input int k, input string tag, input int b, input logic [63:0] m);
        check(k, {tag, " dut peak_bin"}, 64'(peak_bin_w[k]), 64'(b));
        check(k, {tag, " dut peak_mag"}, 64'(peak_mag_w[k]), m);
        check(k, {tag, " model peak_bin"}, 64'(held_pb[k]), 64'(b));
        check(k, {tag, " model peak_mag"}, held_pm[k], m);
    endtask

    initial begin
        int pv0 [2];
        int fe0 [2];
        repeat (2) @(posedge clk_in);
        #2;
        check_zero("reset");
        @(posedge clk_in);
        #1;
        RST = 1'b0;
        idle(3);

        clear_tone();
        tre[9] = 1000;
        tim[9] = -500;
        for (int k = 0; k < 2; k++) pv0[k] = pv_cnt[k];
        send_frame(N, 0, 1'b0);
        idle(5);
        for (int k = 0; k < 2; k++) begin
            check_peak(k, "tone9", 9, 64'd1250000);
            check(k, "tone9 pulses", 64'(pv_cnt[k] - pv0[k]), 64'd1);
        end

        clear_tone();
        tre[40] = -131072;
        tim[40] = -131072;
        send_frame(N, 0, 1'b0);
        idle(5);
        for (int k = 0; k < 2; k++) check_peak(k, "fullscale", 40, 64'd34359738368);

        clear_tone();
        tre[0] = 5000;
        tre[3] = 100;
        tim[7] = 100;
        send_frame(N, 0, 1'b0);
        idle(5);
        check_peak(0, "dc_tie skip", 3, 64'd10000);
        check_peak(1, "dc_tie keep", 0, 64'd25000000);

        clear_tone();
        tre[200] = 300;
        tim[200] = 400;
        send_frame(N, 1, 1'b0);
        idle(5);
        for (int k = 0; k < 2; k++) check_peak(k, "gapped", 200, 64'd250000);

        clear_tone();
        tre[30] = 2000;
        for (int k = 0; k < 2; k++) begin
            pv0[k] = pv_cnt[k];
            fe0[k] = fe_cnt[k];
        end
        send_frame(100, 0, 1'b0);
        tre[30] = 0;
        tre[50] = 700;
        send_frame(N, 0, 1'b0);
        idle(5);
        for (int k = 0; k < 2; k++) begin
            check_peak(k, "resync", 50, 64'd490000);
            check(k, "resync err pulses", 64'(fe_cnt[k] - fe0[k]), 64'd1);
            check(k, "resync peak pulses", 64'(pv_cnt[k] - pv0[k]), 64'd1);
        end

        clear_tone();
        tre[20] = 3000;
        send_frame(128, 0, 1'b0);
        @(posedge clk_in);
        #1;
        ien   = 1'b1;
        iaddr = TS'(128);
        iReal = '0;
        iImag = '0;
        #2;
        RST = 1'b1;
        #1;
        check_zero("async rst");
        ien = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        RST = 1'b0;
        tre[20] = 0;
        tre[60] = 10;
        for (int k = 0; k < 2; k++) pv0[k] = pv_cnt[k];
        send_frame(N, 0, 1'b0);
        idle(5);
        for (int k = 0; k < 2; k++) begin
            check_peak(k, "post-reset", 60, 64'd100);
            check(k, "post-reset pulses", 64'(pv_cnt[k] - pv0[k]), 64'd1);
        end

        for (int k = 0; k < 2; k++) pv0[k] = pv_cnt[k];
        for (int f = 0; f < 8; f++) begin
            for (int s = 0; s < int'($urandom_range(0, 2)); s++)
                drive(1'b1, rnd18(), rnd18(), int'($urandom_range(1, N - 1)));
            for (int i = 0; i < N; i++) begin
                if (f % 2 == 1) begin
                    tre[i] = int'($urandom_range(0, 3));
                    tim[i] = int'($urandom_range(0, 3));
                end else begin
                    tre[i] = rnd18();
                    tim[i] = rnd18();
                end
            end
            send_frame(N, 2, f[1]);
            idle(int'($urandom_range(0, 2)));
        end
        idle(6);
        for (int k = 0; k < 2; k++)
            check(k, "random frame pulses", 64'(pv_cnt[k] - pv0[k]), 64'd8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
